// File: rtl/cont_config_axil_regbank_if.sv
// cont_config_axil_regbank_if: AXI4-Lite bus bundle between PS master and config register bank
interface cont_config_axil_regbank_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  logic [AW-1:0]   awaddr;
  logic [2:0]      awprot;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wvalid;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [AW-1:0]   araddr;
  logic [2:0]      arprot;
  logic            arvalid;
  logic            arready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready;
  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/cont_config_axil_regbank.sv
// cont_config_axil_regbank: AXI4-Lite register bank with RW, read-only status and self-clearing pulse registers
module cont_config_axil_regbank #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int NUM_REGS = 8,
  parameter int C_S_AXI_ADDR_WIDTH = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0,
  parameter logic [NUM_REGS-1:0] PULSE_MASK = '0,
  parameter logic [C_S_AXI_DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic S_AXI_ACLK,
  input  logic S_AXI_ARESET,
  cont_config_axil_regbank_if.slave s_axi,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] regs_out,
  input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] status_in,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] pulse_out
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int NB = DW / 8;
  localparam int LSB = $clog2(NB);
  localparam int IW = $clog2(NUM_REGS);
  logic clk, rst;
  assign clk = S_AXI_ACLK;
  assign rst = S_AXI_ARESET;
  logic unused_prot;
  assign unused_prot = ^{s_axi.awprot, s_axi.arprot};
  logic aw_full, w_full, bvalid, rvalid, commit, ar_hs, aw_oor, r_oor;
  logic [AW-1:0] aw_addr;
  logic [DW-1:0] w_data, wmask, rdata;
  logic [NB-1:0] w_strb;
  logic [1:0] bresp, rresp;
  logic [IW-1:0] w_idx, r_idx;
  logic [NUM_REGS-1:0][DW-1:0] rg, st;
  assign rg = regs_out;
  assign st = status_in;
  assign w_idx = aw_addr[LSB +: IW];
  assign r_idx = s_axi.araddr[LSB +: IW];
  assign aw_oor = (aw_addr >> (LSB + IW)) != '0;
  assign r_oor = (s_axi.araddr >> (LSB + IW)) != '0;
  // a pending B being accepted this cycle frees the response slot for the next commit
  assign commit = aw_full && w_full && (!bvalid || s_axi.bready);
  assign ar_hs = s_axi.arvalid && s_axi.arready;
  assign s_axi.awready = !aw_full;
  assign s_axi.wready = !w_full;
  assign s_axi.bvalid = bvalid;
  assign s_axi.bresp = bresp;
  assign s_axi.arready = !rvalid || s_axi.rready;
  assign s_axi.rvalid = rvalid;
  assign s_axi.rdata = rdata;
  assign s_axi.rresp = rresp;
  for (genvar k = 0; k < NB; k++) begin : g_m
    assign wmask[8*k +: 8] = {8{w_strb[k]}};
  end
  always_ff @(posedge clk)
    if (rst) begin
      aw_full <= 1'b0;
      w_full <= 1'b0;
      bvalid <= 1'b0;
      bresp <= 2'b00;
    end else begin
      aw_full <= aw_full ? !commit : s_axi.awvalid;
      w_full <= w_full ? !commit : s_axi.wvalid;
      bvalid <= commit || (bvalid && !s_axi.bready);
      bresp <= commit ? (aw_oor ? 2'b10 : 2'b00) : bresp;
    end
  always_ff @(posedge clk) begin
    if (!aw_full && s_axi.awvalid) aw_addr <= s_axi.awaddr;
    if (!w_full && s_axi.wvalid) begin
      w_data <= s_axi.wdata;
      w_strb <= s_axi.wstrb;
    end
  end
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_r
    localparam bit IS_RO = RO_MASK[i];
    localparam bit IS_PULSE = PULSE_MASK[i] && !RO_MASK[i];
    logic [DW-1:0] r, p;
    logic hit;
    assign hit = commit && !aw_oor && w_idx == IW'(i);
    always_ff @(posedge clk)
      if (rst) begin
        r <= (IS_RO || IS_PULSE) ? '0 : RESET_VALUE;
        p <= '0;
      end else begin
        if (hit && !IS_RO && !IS_PULSE) r <= (r & ~wmask) | (w_data & wmask);
        p <= (hit && IS_PULSE) ? (w_data & wmask) : '0;
      end
    assign regs_out[i*DW +: DW] = r;
    assign pulse_out[i*DW +: DW] = p;
  end
  // regs_out already reads 0 for pulse slots, so only RO needs a separate source
  always_ff @(posedge clk)
    if (rst) begin
      rvalid <= 1'b0;
      rdata <= '0;
      rresp <= 2'b00;
    end else begin
      if (ar_hs) begin
        rdata <= r_oor ? '0 : (RO_MASK[r_idx] ? st[r_idx] : rg[r_idx]);
        rresp <= r_oor ? 2'b10 : 2'b00;
      end
      rvalid <= ar_hs || (rvalid && !s_axi.rready);
    end
endmodule
